// File: rtl/mux_scan_serializer.sv
// Drives the select lines of an external 8:1 multiplexer through all eight inputs,
// assembles the sampled bits into a byte and offers it on a valid/ready output.
module mux_scan_serializer #(
   parameter bit AUTO_RESTART = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       y_in,
   output logic       s2,
   output logic       s1,
   output logic       s0,
   output logic [7:0] data_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy
);

   localparam int unsigned W  = 8;
   localparam int unsigned IW = 3;

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   sel_q, sel_d;
   logic [W-1:0]    cap_q, cap_d;
   logic [W-1:0]    data_q, data_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;

   // Next-state, capture and output-register inputs
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cap_d   = cap_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (start || AUTO_RESTART) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            cap_d[idx_q] = y_in;
            idx_d        = idx_q + IW'(1);
            if (idx_q == IW'(W - 1)) begin
               // last bit goes straight into the output word via cap_d
               state_d = HOLD;
               data_d  = cap_d;
               valid_d = 1'b1;
               idx_d   = '0;
            end
         end
         HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               idx_d   = '0;
               state_d = (start || AUTO_RESTART) ? SCAN : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
      // selects follow the scan index only while scanning
      sel_d  = (state_d == SCAN) ? idx_d : '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sel_q   <= '0;
         cap_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         cap_q   <= cap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   // idx bit 0 drives s2 so that idx k selects mux input k
   assign s2        = sel_q[0];
   assign s1        = sel_q[1];
   assign s0        = sel_q[2];
   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: two serializers (AUTO_RESTART 0 and 1) each fed by a modelled 8:1 mux.
module tb_mux_scan_serializer;

   logic       clk = 1'b0;
   logic       reset, start, out_ready;
   logic [7:0] mux_in;
   logic       y_in, s2, s1, s0, out_valid, busy;
   logic [7:0] data_out;

   logic       rst_ar, ready_ar;
   logic [7:0] mux_ar;
   logic       y_ar, s2_ar, s1_ar, s0_ar, valid_ar, busy_ar;
   logic [7:0] data_ar;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // select index is {s0,s1,s2}; input a is bit 0
   assign y_in = mux_in[{s0, s1, s2}];
   assign y_ar = mux_ar[{s0_ar, s1_ar, s2_ar}];

   mux_scan_serializer #(.AUTO_RESTART(1'b0)) dut (
      .clk(clk), .reset(reset), .start(start), .y_in(y_in),
      .s2(s2), .s1(s1), .s0(s0), .data_out(data_out),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   mux_scan_serializer #(.AUTO_RESTART(1'b1)) dut_ar (
      .clk(clk), .reset(rst_ar), .start(1'b0), .y_in(y_ar),
      .s2(s2_ar), .s1(s1_ar), .s0(s0_ar), .data_out(data_ar),
      .out_valid(valid_ar), .out_ready(ready_ar), .busy(busy_ar)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // outputs packed as {busy, valid, sel[2:0]}
   function automatic logic [7:0] st();
      return {3'b000, busy, out_valid, s0, s1, s2};
   endfunction

   function automatic logic [7:0] st_ar();
      return {3'b000, busy_ar, valid_ar, s0_ar, s1_ar, s2_ar};
   endfunction

   initial begin
      logic [7:0] words [3];
      words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h81;

      reset = 1'b1; start = 1'b0; out_ready = 1'b1; mux_in = 8'h4D;
      rst_ar = 1'b1; ready_ar = 1'b1; mux_ar = 8'h00;
      tick(); tick();
      chk("reset_status", st(), 8'h00);
      chk("reset_data", data_out, 8'h00);
      chk("reset_status_ar", st_ar(), 8'h00);

      // no start after reset release: stay idle
      reset = 1'b0;
      tick();
      chk("idle_no_start", st(), 8'h00);

      // basic word: a..h = 1,0,1,1,0,0,1,0 -> 8'h4D
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("scan_sel_%0d", k), st(), 8'h10 | 8'(k));
         tick();
      end
      chk("basic_status", st(), 8'h18);
      chk("basic_data", data_out, 8'h4D);
      tick();
      chk("basic_after_hs", st(), 8'h00);
      chk("basic_data_retained", data_out, 8'h4D);

      // stall in HOLD for 5 cycles, start pulses in SCAN and HOLD ignored
      mux_in = 8'hA7; out_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      chk("start_in_scan_ignored", st(), 8'h14);
      tick(); tick(); tick(); tick();
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall_status_%0d", c), st(), 8'h18);
         chk($sformatf("stall_data_%0d", c), data_out, 8'hA7);
         start = (c == 2) ? 1'b1 : 1'b0;
         tick();
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("stall_release", st(), 8'h00);
      tick(); tick();
      chk("no_queued_start", st(), 8'h00);
      chk("stall_data_retained", data_out, 8'hA7);

      // start held: back-to-back words every 9 cycles
      mux_in = words[0]; start = 1'b1;
      tick();
      for (int w = 0; w < 3; w++) begin
         chk($sformatf("b2b_first_sel_%0d", w), st(), 8'h10);
         repeat (8) tick();
         chk($sformatf("b2b_status_%0d", w), st(), 8'h18);
         chk($sformatf("b2b_data_%0d", w), data_out, words[w]);
         if (w < 2) mux_in = words[w + 1];
         else start = 1'b0;
         tick();
      end
      chk("b2b_end_idle", st(), 8'h00);

      // reset at idx 4 discards the partial word
      mux_in = 8'hFF; start = 1'b1; tick(); start = 1'b0;
      repeat (4) tick();
      chk("pre_reset_idx4", st(), 8'h14);
      reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
      chk("mid_reset_status", st(), 8'h00);
      chk("mid_reset_data", data_out, 8'h00);
      mux_in = 8'h3C; start = 1'b1; tick(); start = 1'b0;
      repeat (8) tick();
      chk("post_reset_status", st(), 8'h18);
      chk("post_reset_data", data_out, 8'h3C);
      tick();

      // AUTO_RESTART: leaves IDLE on the first edge, words run continuously
      mux_ar = 8'h96; rst_ar = 1'b0;
      tick();
      chk("ar_first_scan", st_ar(), 8'h10);
      repeat (8) tick();
      chk("ar_status_0", st_ar(), 8'h18);
      chk("ar_data_0", data_ar, 8'h96);
      mux_ar = 8'h2B;
      tick();
      chk("ar_restart_0", st_ar(), 8'h10);
      repeat (8) tick();
      chk("ar_status_1", st_ar(), 8'h18);
      chk("ar_data_1", data_ar, 8'h2B);
      mux_ar = 8'hE4; ready_ar = 1'b0;
      tick(); tick();
      chk("ar_stall_status", st_ar(), 8'h18);
      chk("ar_stall_data", data_ar, 8'h2B);
      ready_ar = 1'b1;
      tick();
      chk("ar_restart_1", st_ar(), 8'h10);
      repeat (8) tick();
      chk("ar_data_2", data_ar, 8'hE4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
